// File: rtl/plic_gateway_arb_if.sv
// Port bundle between the PLIC register front-end (master) and the gateway/arbiter core (slave).
interface plic_gateway_arb_if #(
  parameter int NSRC   = 31,
  parameter int NTGT   = 2,
  parameter int PRIO_W = 3
);
  localparam int ID_W = $clog2(NSRC + 1);

  logic [NSRC-1:0]                 irq_i;
  logic [NSRC-1:0]                 mode_i;
  logic [NSRC-1:0][PRIO_W-1:0]     prio_i;
  logic [NTGT-1:0][NSRC-1:0]       ie_i;
  logic [NTGT-1:0][PRIO_W-1:0]     thold_i;
  logic [NTGT-1:0]                 claim_i;
  logic [NTGT-1:0][ID_W-1:0]       claim_id_o;
  logic [NTGT-1:0]                 complete_i;
  logic [NTGT-1:0][ID_W-1:0]       complete_id_i;
  logic [NTGT-1:0]                 irq_o;
  logic [NSRC-1:0]                 ip_o;

  modport master (
    output irq_i, mode_i, prio_i, ie_i, thold_i, claim_i, complete_i, complete_id_i,
    input  claim_id_o, irq_o, ip_o
  );
  modport slave (
    input  irq_i, mode_i, prio_i, ie_i, thold_i, claim_i, complete_i, complete_id_i,
    output claim_id_o, irq_o, ip_o
  );
endinterface

// File: rtl/plic_gateway_arb.sv
// PLIC core: per-source gateways plus per-target priority arbitration and claim/complete.
// Define PLIC_EDGE_CNT_EN to queue rising edges seen while a source is pending or in flight.
module plic_gateway_arb_gw #(
  parameter int CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq,
  input  logic mode,
  input  logic claim_hit,
  input  logic cmpl_hit,
  output logic ip_d,
  output logic ip_q
);
  typedef enum logic [1:0] {IDLE, PEND, FLIGHT} gw_state_e;

  gw_state_e state_q, state_d;
  logic      irq_q;
  logic      edge_w;
`ifdef PLIC_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
`endif

  assign edge_w = irq & ~irq_q;

  always_comb begin
    state_d = state_q;
`ifdef PLIC_EDGE_CNT_EN
    cnt_d  = cnt_q;
    mode_d = mode_q;
    // Edges while busy are banked (saturating); an edge coincident with a complete still counts.
    if (state_q != IDLE && mode_q && edge_w && cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
    unique case (state_q)
      IDLE: if (mode ? edge_w : irq) begin
        state_d = PEND;
`ifdef PLIC_EDGE_CNT_EN
        mode_d  = mode;
`endif
      end
      PEND: if (claim_hit) state_d = FLIGHT;
      FLIGHT: if (cmpl_hit) begin
`ifdef PLIC_EDGE_CNT_EN
        if (cnt_d != '0) begin
          state_d = PEND;
          cnt_d   = cnt_d - 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
`ifdef PLIC_EDGE_CNT_EN
      cnt_q   <= '0;
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
`ifdef PLIC_EDGE_CNT_EN
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
`endif
    end
  end

  assign ip_d = (state_d == PEND);
  assign ip_q = (state_q == PEND);
endmodule

module plic_gateway_arb #(
  parameter int NSRC   = 31,
  parameter int NTGT   = 2,
  parameter int PRIO_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  plic_gateway_arb_if.slave  bus
);
  localparam int ID_W = $clog2(NSRC + 1);

  logic [NSRC-1:0]             ip_d, ip_q;
  logic [NSRC-1:0]             claim_hit, cmpl_hit;
  logic [NTGT-1:0][ID_W-1:0]   best_id_q, best_id_d, claim_id;
  logic [NTGT-1:0][PRIO_W-1:0] best_prio_d;
  logic [NTGT-1:0]             irq_q;

  for (genvar s = 0; s < NSRC; s++) begin : g_gw
    plic_gateway_arb_gw #(.CNT_W(CNT_W)) u_gw (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .irq       (bus.irq_i[s]),
      .mode      (bus.mode_i[s]),
      .claim_hit (claim_hit[s]),
      .cmpl_hit  (cmpl_hit[s]),
      .ip_d      (ip_d[s]),
      .ip_q      (ip_q[s])
    );
  end

  // A lower-numbered target claiming the same ID in the same cycle wins; the other reads 0.
  always_comb begin
    claim_id = '0;
    for (int t = 0; t < NTGT; t++) begin
      claim_id[t] = irq_q[t] ? best_id_q[t] : '0;
      for (int u = 0; u < t; u++)
        if (bus.claim_i[t] && bus.claim_i[u] && irq_q[u] && best_id_q[u] == best_id_q[t])
          claim_id[t] = '0;
    end
  end

  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int t = 0; t < NTGT; t++)
      for (int s = 0; s < NSRC; s++) begin
        if (bus.claim_i[t] && claim_id[t] == ID_W'(s + 1))         claim_hit[s] = 1'b1;
        if (bus.complete_i[t] && bus.complete_id_i[t] == ID_W'(s + 1)) cmpl_hit[s] = 1'b1;
      end
  end

  // Arbitrate on next-state pending so a source claimed now never wins the next cycle.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int t = 0; t < NTGT; t++)
      for (int s = 0; s < NSRC; s++)
        if (ip_d[s] && bus.ie_i[t][s] && bus.prio_i[s] > best_prio_d[t]) begin
          best_prio_d[t] = bus.prio_i[s];
          best_id_d[t]   = ID_W'(s + 1);
        end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_id_q <= '0;
      irq_q     <= '0;
    end else begin
      best_id_q <= best_id_d;
      for (int t = 0; t < NTGT; t++) irq_q[t] <= best_prio_d[t] > bus.thold_i[t];
    end
  end

  assign bus.claim_id_o = claim_id;
  assign bus.irq_o      = irq_q;
  assign bus.ip_o       = ip_q;
endmodule

// File: tb/tb_plic_gateway_arb.sv
// Directed bench for plic_gateway_arb: expectations queued per cycle and popped at the sample point.
module tb_plic_gateway_arb;
  localparam int NSRC = 31, NTGT = 2, PRIO_W = 3;
  localparam int K_IRQ = 0, K_CID = 1, K_IP = 2, K_IPALL = 3;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic clk, rst;
  int   checks, failures;
  exp_t sb[$];

  plic_gateway_arb_if #(.NSRC(NSRC), .NTGT(NTGT), .PRIO_W(PRIO_W)) bus ();

  plic_gateway_arb #(.NSRC(NSRC), .NTGT(NTGT), .PRIO_W(PRIO_W), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_IRQ:   return {31'b0, bus.irq_o[idx]};
      K_CID:   return 32'(bus.claim_id_o[idx]);
      K_IP:    return {31'b0, bus.ip_o[idx]};
      default: return {1'b0, bus.ip_o};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int kind, input int idx, input int val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic settle();
    #1;
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = sb.pop_front();
      o = observe(e.kind, e.idx);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.claim_i       = '0;
    bus.complete_i    = '0;
    bus.complete_id_i = '0;
  endtask

  task automatic cfg_clear();
    bus.irq_i   = '0;
    bus.mode_i  = '0;
    bus.prio_i  = '0;
    bus.ie_i    = '0;
    bus.thold_i = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    cfg_clear();
    bus.claim_i = '0; bus.complete_i = '0; bus.complete_id_i = '0;

    // reset state
    tick(); tick();
    expect_v("rst_ip", K_IPALL, 0, 0);
    expect_v("rst_irq0", K_IRQ, 0, 0);
    expect_v("rst_irq1", K_IRQ, 1, 0);
    expect_v("rst_cid0", K_CID, 0, 0);
    settle();
    rst = 1'b0;

    // level source 3: pend, claim, complete with line held, re-pend
    tick();
    bus.irq_i[2] = 1'b1; bus.prio_i[2] = 3'd2; bus.ie_i[0][2] = 1'b1; bus.thold_i[0] = 3'd1;
    settle();
    tick();
    expect_v("lvl_irq", K_IRQ, 0, 1); expect_v("lvl_cid", K_CID, 0, 3); expect_v("lvl_ip", K_IP, 2, 1);
    settle();
    bus.claim_i[0] = 1'b1;
    expect_v("lvl_cid_claim", K_CID, 0, 3);
    settle();
    tick();
    expect_v("lvl_ip_claimed", K_IP, 2, 0); expect_v("lvl_irq_claimed", K_IRQ, 0, 0);
    expect_v("lvl_cid_claimed", K_CID, 0, 0);
    settle();
    tick();
    bus.complete_i[0] = 1'b1; bus.complete_id_i[0] = 5'd3;
    settle();
    tick();
    expect_v("lvl_ip_idle", K_IP, 2, 0);
    settle();
    tick();
    expect_v("lvl_repend_ip", K_IP, 2, 1); expect_v("lvl_repend_cid", K_CID, 0, 3);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    bus.irq_i[2] = 1'b0; bus.complete_i[0] = 1'b1; bus.complete_id_i[0] = 5'd3;
    settle();
    tick();
    cfg_clear();

    // priority ordering: 7 (prio 6), then tie 2/5 at prio 4 -> lowest ID first
    tick();
    bus.irq_i[1] = 1'b1; bus.irq_i[4] = 1'b1; bus.irq_i[6] = 1'b1;
    bus.prio_i[1] = 3'd4; bus.prio_i[4] = 3'd4; bus.prio_i[6] = 3'd6;
    bus.ie_i[0][1] = 1'b1; bus.ie_i[0][4] = 1'b1; bus.ie_i[0][6] = 1'b1;
    settle();
    tick();
    expect_v("arb_first", K_CID, 0, 7); expect_v("arb_irq", K_IRQ, 0, 1);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    expect_v("arb_second", K_CID, 0, 2);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    expect_v("arb_third", K_CID, 0, 5);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    expect_v("arb_empty_irq", K_IRQ, 0, 0); expect_v("arb_empty_cid", K_CID, 0, 0);
    expect_v("arb_empty_ip", K_IPALL, 0, 0);
    bus.irq_i = '0;
    bus.complete_i[0] = 1'b1; bus.complete_id_i[0] = 5'd7;
    settle();
    tick();
    bus.complete_i = 2'b11; bus.complete_id_i[0] = 5'd2; bus.complete_id_i[1] = 5'd5;
    settle();
    tick();
    cfg_clear();

    // two targets claim source 4 in the same cycle
    tick();
    bus.irq_i[3] = 1'b1; bus.prio_i[3] = 3'd1; bus.ie_i[0][3] = 1'b1; bus.ie_i[1][3] = 1'b1;
    settle();
    tick();
    expect_v("dup_pre_cid0", K_CID, 0, 4); expect_v("dup_pre_cid1", K_CID, 1, 4);
    settle();
    bus.claim_i = 2'b11;
    expect_v("dup_cid0", K_CID, 0, 4); expect_v("dup_cid1", K_CID, 1, 0);
    settle();
    tick();
    expect_v("dup_ip", K_IP, 3, 0); expect_v("dup_irq1", K_IRQ, 1, 0);
    bus.irq_i[3] = 1'b0;
    settle();
    tick();
    bus.complete_i[1] = 1'b1; bus.complete_id_i[1] = 5'd4;
    settle();
    tick();
    bus.irq_i[3] = 1'b1;
    settle();
    tick();
    expect_v("dup_idle_repend", K_IP, 3, 1); expect_v("dup_cid1_again", K_CID, 1, 4);
    settle();
    bus.claim_i[1] = 1'b1;
    settle();
    tick();
    bus.irq_i[3] = 1'b0; bus.complete_i[1] = 1'b1; bus.complete_id_i[1] = 5'd4;
    settle();
    tick();
    cfg_clear();

    // threshold boundary on source 6
    tick();
    bus.irq_i[5] = 1'b1; bus.prio_i[5] = 3'd3; bus.ie_i[0][5] = 1'b1; bus.thold_i[0] = 3'd3;
    settle();
    tick();
    expect_v("thr_eq_irq", K_IRQ, 0, 0); expect_v("thr_eq_cid", K_CID, 0, 0);
    expect_v("thr_eq_ip", K_IP, 5, 1);
    settle();
    bus.thold_i[0] = 3'd2;
    settle();
    tick();
    expect_v("thr_lt_irq", K_IRQ, 0, 1); expect_v("thr_lt_cid", K_CID, 0, 6);
    settle();
    bus.prio_i[5] = 3'd0; bus.thold_i[0] = 3'd0;
    settle();
    tick();
    expect_v("prio0_irq", K_IRQ, 0, 0);
    settle();
    tick();
    expect_v("prio0_irq_hold", K_IRQ, 0, 0); expect_v("prio0_cid", K_CID, 0, 0);
    settle();
    cfg_clear();

    // edge source 1 pulsing while in flight
    tick();
    bus.irq_i[0] = 1'b1; bus.mode_i[0] = 1'b1; bus.prio_i[0] = 3'd5; bus.ie_i[0][0] = 1'b1;
    settle();
    tick();
    expect_v("edge_ip", K_IP, 0, 1); expect_v("edge_cid", K_CID, 0, 1);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    bus.irq_i[0] = 1'b0;
    expect_v("edge_flight_ip", K_IP, 0, 0);
    settle();
    for (int p = 0; p < 3; p++) begin
      tick(); bus.irq_i[0] = 1'b1; settle();
      tick(); bus.irq_i[0] = 1'b0; settle();
    end
    tick();
    bus.complete_i[0] = 1'b1; bus.complete_id_i[0] = 5'd1;
    settle();
    tick();
`ifdef PLIC_EDGE_CNT_EN
    for (int r = 0; r < 3; r++) begin
      expect_v("edge_cnt_ip", K_IP, 0, 1); expect_v("edge_cnt_cid", K_CID, 0, 1);
      settle();
      bus.claim_i[0] = 1'b1;
      settle();
      tick();
      expect_v("edge_cnt_claimed", K_IP, 0, 0);
      bus.complete_i[0] = 1'b1; bus.complete_id_i[0] = 5'd1;
      settle();
      tick();
    end
    expect_v("edge_cnt_done_ip", K_IP, 0, 0); expect_v("edge_cnt_done_irq", K_IRQ, 0, 0);
    settle();
`else
    expect_v("edge_drop_ip", K_IP, 0, 0); expect_v("edge_drop_irq", K_IRQ, 0, 0);
    expect_v("edge_drop_cid", K_CID, 0, 0);
    settle();
`endif
    cfg_clear();

    // reset with sources 10, 9 in flight and 8 pending; line 8 held through reset
    tick();
    bus.irq_i[7] = 1'b1; bus.irq_i[8] = 1'b1; bus.irq_i[9] = 1'b1;
    bus.prio_i[7] = 3'd1; bus.prio_i[8] = 3'd2; bus.prio_i[9] = 3'd3;
    bus.ie_i[0][7] = 1'b1; bus.ie_i[0][8] = 1'b1; bus.ie_i[0][9] = 1'b1;
    settle();
    tick();
    expect_v("rmf_cid10", K_CID, 0, 10);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    expect_v("rmf_cid9", K_CID, 0, 9);
    settle();
    bus.claim_i[0] = 1'b1;
    settle();
    tick();
    expect_v("rmf_cid8", K_CID, 0, 8);
    settle();
    bus.irq_i[8] = 1'b0; bus.irq_i[9] = 1'b0;
    rst = 1'b1;
    tick();
    expect_v("rmf_ip", K_IPALL, 0, 0); expect_v("rmf_irq0", K_IRQ, 0, 0);
    expect_v("rmf_irq1", K_IRQ, 1, 0); expect_v("rmf_cid", K_CID, 0, 0);
    settle();
    rst = 1'b0;
    tick();
    expect_v("rmf_repend_ip", K_IPALL, 0, 32'h80); expect_v("rmf_repend_cid", K_CID, 0, 8);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plic_gateway_arb.md
# plic_gateway_arb

Parametrised interrupt core for the next-generation PLIC. It provides per-source gateways (level or edge), pending tracking and per-target priority arbitration for `NSRC` sources and `NTGT` targets (hart contexts), with a claim/complete handshake per target. It sits behind the APB4 register front-end, which owns the priority, enable, threshold and mode registers and drives them in as static configuration.

## Interface
Parameters:
- `NSRC`, 31: number of interrupt sources; source IDs are 1..NSRC, and ID 0 means "none".
- `NTGT`, 2: number of targets.
- `PRIO_W`, 3: priority and threshold width.
- `CNT_W`, 4: edge-counter width; used only with `PLIC_EDGE_CNT_EN`.
- `ID_W` (localparam), `$clog2(NSRC+1)`: ID width.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `irq_i` in NSRC: raw device interrupts; bit k is source k+1, synchronous to `clk_i`.
- `mode_i` in NSRC: per-source trigger mode; 1 = edge (rising), 0 = level (high).
- `prio_i` in NSRC*PRIO_W: per-source priority; 0 = never interrupts.
- `ie_i` in NTGT*NSRC: per-target enable bits.
- `thold_i` in NTGT*PRIO_W: per-target threshold.
- `claim_i` in NTGT: claim strobe, one cycle (the APB read of the claim register).
- `claim_id_o` out NTGT*ID_W: ID returned to a claimer; valid every cycle, 0 if nothing to claim.
- `complete_i` in NTGT: complete strobe, one cycle.
- `complete_id_i` in NTGT*ID_W: ID being completed.
- `irq_o` out NTGT: per-target interrupt request (registered).
- `ip_o` out NSRC: pending bits (registered), for readback.

## Operation
- Each source has a gateway FSM with states IDLE, PEND and FLIGHT. `ip_o` is 1 exactly in PEND.
  - IDLE→PEND:
    - level mode: when `irq_i` is high;
    - edge mode: when `irq_i & ~irq_q` (`irq_q` is a per-source 1-cycle delayed sample).
    - `mode_i` is sampled only on this transition.
  - PEND→FLIGHT: when any target's effective claim selects this ID.
  - FLIGHT→IDLE: when any target completes with `complete_id_i` equal to this ID.
    - A level source still high re-pends one cycle later.
  - A complete for a source not in FLIGHT, or for ID 0 or an ID > NSRC, is ignored.
- Arbitration per target t:
  - Candidates are sources with next-state pending (`ip_d`), `ie_i[t]` set and priority > 0.
  - Winner is the highest priority; ties go to the lowest ID.
  - The winner is registered into `best_id_q[t]` and `best_prio_q[t]`.
  - Because candidates come from `ip_d`, a source claimed this cycle is excluded from the next cycle's results.
- `irq_o[t]` is registered: `best_prio_q[t] > thold_i[t]`.
- Claim:
  - `claim_id_o[t] = irq_o[t] ? best_id_q[t] : 0`.
  - If targets t and u (u < t) both strobe `claim_i` in the same cycle with equal nonzero IDs, u gets the ID and t gets 0.
  - A claim that yields 0 has no effect.
- Claim and complete of different sources in the same cycle are both processed.
- Reset:
  - All FSMs go to IDLE and `irq_q`, `best_*_q` and counters clear to 0.
  - `irq_o`, `ip_o` and `claim_id_o` read 0 in the first cycle after reset.
  - Reset mid-flight discards all outstanding claims.

## Timing
- Level source rises in cycle N: `ip_o` and `irq_o` are high from N+1 (`ip_o` when the source is in IDLE; `irq_o` when the source is enabled and its priority exceeds the threshold).
- Edge source: same latency, measured from the cycle in which `irq_i` first samples high.
- Claim strobed in cycle N (returning `claim_id_o` of cycle N):
  - `ip_o` for that source clears at N+1;
  - `irq_o` and `claim_id_o` reflect the next winner at N+1.
- Complete strobed in cycle N: the source is in IDLE at N+1; a level source still high is pending again at N+2.
- Changes to `prio_i`, `ie_i` and `thold_i` reach `irq_o` one cycle later.
- There are no stalls; all strobes are accepted every cycle.

## Configuration
- `PLIC_EDGE_CNT_EN` defined:
  - Each edge-mode source has a `CNT_W`-bit saturating counter of rising edges seen while in PEND or FLIGHT.
  - An edge in the same cycle as a complete is counted.
  - On complete with counter > 0 after that count: go FLIGHT→PEND and decrement the counter, instead of going to IDLE.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- Not defined: edges seen in PEND or FLIGHT are dropped; no counter logic is generated.

## Test plan
- Level source 3 with prio 2, `ie[0]`=1 and thold 1:
  - raise `irq_i[2]` → `irq_o[0]`=1 next cycle, `claim_id_o[0]`=3;
  - claim → `ip_o[2]`=0;
  - complete ID 3 with the line still high → pending again 2 cycles later.
- Sources 5 and 2 both at prio 4, source 7 at prio 6, all enabled for target 0: claims return 7, then 2, then 5; after that `irq_o[0]`=0 and `claim_id_o`=0.
- Both targets enabled for source 4 only and both claim in the same cycle → target 0 gets 4, target 1 gets 0; complete from target 1 with ID 4 → source returns to IDLE.
- Threshold equal to priority (both 3) → `irq_o`=0; lower threshold to 2 → `irq_o`=1 next cycle; priority 0 with threshold 0 → never asserts.
- Edge source 1 pulses 3 times while in FLIGHT:
  - with `PLIC_EDGE_CNT_EN` → three further claim/complete rounds return ID 1;
  - without it → after complete the source is IDLE and `ip_o[0]`=0.
- Assert `rst_i` for 1 cycle with two sources in FLIGHT and one in PEND → next cycle all `ip_o`, `irq_o` and `claim_id_o` = 0; a held level line re-pends one cycle after release.
